// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the ALU control unit and alu_multicycle.
//
// Handshake: the requester raises start with control/input1/input2/shamt
// valid; the ALU accepts on the first rising edge where it is idle (busy low)
// and start is high. busy stays high from the cycle after accept through the
// done cycle; done is a one-cycle pulse and out/out_hi/flags/div_by_zero are
// valid from that cycle until the next operation completes. start while busy
// is ignored and never queued.
interface alu_multicycle_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         control;
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;
    logic [WIDTH-1:0]   out_hi;
    logic [2:0]         flags;
    logic               div_by_zero;

    modport master (
        output start, control, input1, input2, shamt,
        input  busy, done, out, out_hi, flags, div_by_zero
    );

    modport slave (
        input  start, control, input1, input2, shamt,
        output busy, done, out, out_hi, flags, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/comp/and/xor, 1-bit-per-cycle shifts,
// shift-add unsigned multiply and restoring unsigned divide.
// Results are registered on entry to DONE and held until the next completion.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    alu_multicycle_if.slave bus,
    output logic [1:0]      fsm_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Working registers: lo_q holds the shifted value / multiplier-product-low /
    // dividend-quotient, hi_q holds product-high / partial remainder.
    logic [3:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;

    // Registered results.
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_hi_q;
    logic [2:0]       flags_q;
    logic             dbz_q;

    logic accept;
    logic iterative;
    logic is_shift;
    logic last_step;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] q_out, q_hi;
    logic [2:0]       q_flags;
    logic             q_dbz;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fin_out, fin_hi;
    logic [2:0]       fin_flags;

    // {carry, zero, sign} for the ops whose flags follow the result directly.
    function automatic logic [2:0] std_flags(input logic [WIDTH-1:0] v, input logic c);
        return {c, (v == '0), v[WIDTH-1]};
    endfunction

    assign accept    = (state == IDLE) && bus.start;
    assign last_step = (state == RUN) && (cnt_q == CNT_W'(1));
    assign is_shift  = (bus.control == OP_SHL) || (bus.control == OP_SHR) ||
                       (bus.control == OP_SRA);

    // Decide whether the requested op needs RUN cycles; zero shifts and
    // divide-by-zero complete straight away.
    always_comb begin
        iterative = 1'b0;
        case (bus.control)
            OP_SHL, OP_SHR, OP_SRA: iterative = (bus.shamt != '0);
            OP_MULU:                iterative = 1'b1;
            OP_DIVU:                iterative = (bus.input2 != '0);
            default:                iterative = 1'b0;
        endcase
    end

    assign add_sum = {1'b0, bus.input1} + {1'b0, bus.input2};

    // Result of ops that finish in the accept cycle, taken from the live inputs.
    always_comb begin
        q_out   = '0;
        q_hi    = '0;
        q_flags = 3'b000;
        q_dbz   = 1'b0;
        case (bus.control)
            OP_ADD: begin
                q_out   = add_sum[WIDTH-1:0];
                q_flags = std_flags(add_sum[WIDTH-1:0], add_sum[WIDTH]);
            end
            OP_COMP: begin
                q_out   = ~bus.input2 + WIDTH'(1);
                q_flags = std_flags(~bus.input2 + WIDTH'(1), 1'b0);
            end
            OP_AND: begin
                q_out   = bus.input1 & bus.input2;
                q_flags = std_flags(bus.input1 & bus.input2, 1'b0);
            end
            OP_XOR: begin
                q_out   = bus.input1 ^ bus.input2;
                q_flags = std_flags(bus.input1 ^ bus.input2, 1'b0);
            end
            OP_SHL, OP_SHR, OP_SRA: begin
                q_out   = bus.input1;
                q_flags = std_flags(bus.input1, 1'b0);
            end
            OP_DIVU: begin
                q_out   = '1;
                q_hi    = bus.input1;
                q_dbz   = 1'b1;
                q_flags = 3'b000;
            end
            default: begin
                q_out   = '0;
                q_flags = 3'b000;
            end
        endcase
    end

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    // One iteration of the latched op: a 1-bit shift, a shift-add step, or a
    // restoring-divide step (negative trial difference keeps the old remainder).
    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        case (op_q)
            OP_SHL: step_lo = {lo_q[WIDTH-2:0], 1'b0};
            OP_SHR: step_lo = {1'b0, lo_q[WIDTH-1:1]};
            OP_SRA: step_lo = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
            OP_MULU: begin
                step_hi = mul_sum[WIDTH:1];
                step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            OP_DIVU: begin
                if (div_diff[WIDTH]) begin
                    step_hi = div_shift[WIDTH-1:0];
                    step_lo = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    step_hi = div_diff[WIDTH-1:0];
                    step_lo = {lo_q[WIDTH-2:0], 1'b1};
                end
            end
            default: begin
                step_hi = hi_q;
                step_lo = lo_q;
            end
        endcase
    end

    // Result formed from the final iteration of an iterative op.
    always_comb begin
        fin_out   = step_lo;
        fin_hi    = '0;
        fin_flags = std_flags(step_lo, 1'b0);
        case (op_q)
            OP_MULU: begin
                fin_hi    = step_hi;
                fin_flags = {(step_hi != '0), ({step_hi, step_lo} == '0), 1'b0};
            end
            OP_DIVU: begin
                fin_hi    = step_hi;
                fin_flags = {1'b0, (step_lo == '0), 1'b0};
            end
            default: begin
                fin_hi    = '0;
                fin_flags = std_flags(step_lo, 1'b0);
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept only in IDLE, RUN until the counter expires, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = iterative ? RUN : DONE;
            RUN:     if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy covers RUN and DONE, done marks the DONE cycle.
    always_comb begin
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        fsm_state = state;
    end

    // Operand capture, iteration and result registers; results change only on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            flags_q  <= 3'b000;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.control;
            b_q   <= bus.input2;
            lo_q  <= bus.input1;
            hi_q  <= '0;
            if (iterative) begin
                cnt_q <= is_shift ? CNT_W'(bus.shamt) : CNT_W'(WIDTH);
                dbz_q <= 1'b0;
            end else begin
                cnt_q    <= '0;
                out_q    <= q_out;
                out_hi_q <= q_hi;
                flags_q  <= q_flags;
                dbz_q    <= q_dbz;
            end
        end else if (state == RUN) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                out_q    <= fin_out;
                out_hi_q <= fin_hi;
                flags_q  <= fin_flags;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.out_hi      = out_hi_q;
    assign bus.flags       = flags_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: reset values, a table of hand-computed vectors,
// multi-cycle corner sequences and random ops against an arithmetic model.
module tb_alu_multicycle;
    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [67:0] exp_q[$];

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] e_out;
        logic [31:0] e_hi;
        logic [2:0]  e_flags;
        logic        e_dbz;
        int          e_lat;
    } vec_t;

    vec_t vecs[15];

    alu_multicycle_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built from the arithmetic definition of each opcode.
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] o, output logic [31:0] h,
                         output logic [2:0] f, output logic dz, output int lat);
        logic [32:0] s;
        logic [63:0] p;
        o = '0; h = '0; f = 3'b000; dz = 1'b0; lat = 1;
        case (c)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; o = s[31:0]; f = {s[32], o == 0, o[31]}; end
            4'b0001: begin o = 32'd0 - b; f = {1'b0, o == 0, o[31]}; end
            4'b0010: begin o = a & b; f = {1'b0, o == 0, o[31]}; end
            4'b0011: begin o = a ^ b; f = {1'b0, o == 0, o[31]}; end
            4'b0100: begin o = a << sh; f = {1'b0, o == 0, o[31]}; lat = int'(sh) + 1; end
            4'b0101: begin o = a >> sh; f = {1'b0, o == 0, o[31]}; lat = int'(sh) + 1; end
            4'b0110: begin o = 32'($signed(a) >>> sh); f = {1'b0, o == 0, o[31]}; lat = int'(sh) + 1; end
            4'b1000: begin
                p = {32'd0, a} * {32'd0, b};
                o = p[31:0]; h = p[63:32];
                f = {h != 0, p == 0, 1'b0};
                lat = 33;
            end
            4'b1001: begin
                if (b == 0) begin
                    o = 32'hFFFF_FFFF; h = a; dz = 1'b1; f = 3'b000; lat = 1;
                end else begin
                    o = a / b; h = a % b; f = {1'b0, o == 0, 1'b0}; lat = 33;
                end
            end
            default: begin o = '0; h = '0; f = 3'b000; lat = 1; end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] e_out, input logic [31:0] e_hi,
                          input logic [2:0] e_flags, input logic e_dbz, input int e_lat);
        logic [67:0] exp;
        int lat;
        exp_q.push_back({e_out, e_hi, e_flags, e_dbz});
        @(negedge clk);
        bus.start = 1'b1; bus.control = c; bus.input1 = a; bus.input2 = b; bus.shamt = sh;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.control = 4'($urandom);
        bus.input1  = $urandom;
        bus.input2  = $urandom;
        bus.shamt   = 5'($urandom);
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(e_lat));
        exp = exp_q.pop_front();
        check({name, "_out"},   64'(bus.out),         64'(exp[67:36]));
        check({name, "_hi"},    64'(bus.out_hi),      64'(exp[35:4]));
        check({name, "_flags"}, 64'(bus.flags),       64'(exp[3:1]));
        check({name, "_dbz"},   64'(bus.div_by_zero), 64'(exp[0]));
        check({name, "_busy"},  64'(bus.busy),        64'd1);
        @(posedge clk); #1;
        check({name, "_ret"}, 64'({bus.done, bus.busy}), 64'd0);
    endtask

    task automatic run_model_op(input string name, input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] o, h;
        logic [2:0]  f;
        logic        dz;
        int          lat;
        model(c, a, b, sh, o, h, f, dz, lat);
        run_op(name, c, a, b, sh, o, h, f, dz, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  ops[11];
        logic [31:0] o, h;
        logic [2:0]  f;
        logic        dz;
        logic [31:0] ra, rb;
        int          lat;
        int          dones;

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b0110, 4'b1000, 4'b1001, 4'b0111, 4'b1100};

        //            ctrl     a             b             sh     out           hi           flags   dbz  lat
        vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 32'h0,      3'b110, 1'b0, 1};
        vecs[1]  = '{4'b0110, 32'h8000_0000, 32'h0,         5'd4,  32'hF800_0000, 32'h0,      3'b001, 1'b0, 5};
        vecs[2]  = '{4'b0100, 32'h0000_0001, 32'h0,         5'd0,  32'h0000_0001, 32'h0,      3'b000, 1'b0, 1};
        vecs[3]  = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0000, 32'h1,      3'b100, 1'b0, 33};
        vecs[4]  = '{4'b1000, 32'h0000_0000, 32'h0000_0005, 5'd0,  32'h0000_0000, 32'h0,      3'b010, 1'b0, 33};
        vecs[5]  = '{4'b1001, 32'd100,       32'd7,         5'd0,  32'd14,        32'd2,      3'b000, 1'b0, 33};
        vecs[6]  = '{4'b1001, 32'd100,       32'd0,         5'd0,  32'hFFFF_FFFF, 32'd100,    3'b000, 1'b1, 1};
        vecs[7]  = '{4'b0000, 32'd3,         32'd4,         5'd0,  32'd7,         32'h0,      3'b000, 1'b0, 1};
        vecs[8]  = '{4'b0001, 32'h0,         32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 32'h0,      3'b001, 1'b0, 1};
        vecs[9]  = '{4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 32'h0,      3'b000, 1'b0, 1};
        vecs[10] = '{4'b0011, 32'h0000_5A5A, 32'h0000_5A5A, 5'd0,  32'h0000_0000, 32'h0,      3'b010, 1'b0, 1};
        vecs[11] = '{4'b0101, 32'h8000_0000, 32'h0,         5'd31, 32'h0000_0001, 32'h0,      3'b000, 1'b0, 32};
        vecs[12] = '{4'b0111, 32'd5,         32'd6,         5'd3,  32'h0,         32'h0,      3'b000, 1'b0, 1};
        vecs[13] = '{4'b0100, 32'h0000_0003, 32'h0,         5'd31, 32'h8000_0000, 32'h0,      3'b001, 1'b0, 32};
        vecs[14] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0,         32'h0,      3'b000, 1'b0, 1};

        rst = 1'b0;
        bus.start = 1'b0; bus.control = '0; bus.input1 = '0; bus.input2 = '0; bus.shamt = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  64'(bus.busy),        64'd0);
        check("rst_done",  64'(bus.done),        64'd0);
        check("rst_out",   64'(bus.out),         64'd0);
        check("rst_hi",    64'(bus.out_hi),      64'd0);
        check("rst_flags", 64'(bus.flags),       64'd0);
        check("rst_dbz",   64'(bus.div_by_zero), 64'd0);
        check("rst_state", 64'(fsm_state),       64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors.
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh,
                   vecs[i].e_out, vecs[i].e_hi, vecs[i].e_flags, vecs[i].e_dbz, vecs[i].e_lat);
        end

        // start held high across DONE->IDLE: accepted again on the first IDLE edge.
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'b0000; bus.input1 = 32'd1; bus.input2 = 32'd1;
        @(posedge clk); #1;
        check("held_done1", 64'({bus.done, bus.busy}), 64'd3);
        @(posedge clk); #1;
        check("held_idle",  64'({bus.done, bus.busy}), 64'd0);
        @(posedge clk); #1;
        check("held_done2", 64'({bus.done, bus.busy}), 64'd3);
        check("held_out",   64'(bus.out), 64'd2);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("held_end",   64'(bus.busy), 64'd0);

        // start pulse and operand change in the middle of a mulu.
        model(4'b1000, 32'h1234_5678, 32'h0000_9ABC, 5'd0, o, h, f, dz, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'b1000; bus.input1 = 32'h1234_5678; bus.input2 = 32'h0000_9ABC;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (lat == 10) begin
                bus.start = 1'b1; bus.control = 4'b0000; bus.input1 = 32'd3; bus.input2 = 32'd4;
            end else if (lat == 11) begin
                bus.start = 1'b0; bus.input1 = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("midmul_lat",   64'(lat),        64'd33);
        check("midmul_out",   64'(bus.out),    64'(o));
        check("midmul_hi",    64'(bus.out_hi), 64'(h));
        check("midmul_flags", 64'(bus.flags),  64'(f));
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("midmul_no_2nd_done", 64'(dones),   64'd0);
        check("midmul_out_held",    64'(bus.out), 64'(o));

        // Reset in the middle of a divu.
        run_model_op("pre_rst_add", 4'b0000, 32'h11, 32'h22, 5'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'b1001; bus.input1 = 32'd1000; bus.input2 = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_busy",  64'(bus.busy),   64'd0);
        check("midrst_done",  64'(bus.done),   64'd0);
        check("midrst_out",   64'(bus.out),    64'd0);
        check("midrst_hi",    64'(bus.out_hi), 64'd0);
        check("midrst_flags", 64'(bus.flags),  64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        check("midrst_abandoned", 64'(dones), 64'd0);
        run_op("post_rst_add", 4'b0000, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 3'b000, 1'b0, 1);

        // Random ops against the model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            logic [4:0] sh;
            c  = ops[$urandom_range(0, 10)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            sh = 5'($urandom_range(0, 31));
            run_model_op($sformatf("rnd%0d", i), c, ra, rb, sh);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU for the next-generation KGP-RISC datapath. It replaces the purely combinational ALU with a start/busy/done handshake and adds iterative barrel-free shifts, unsigned multiply and unsigned divide. It sits between the register file / ALU control unit and the writeback mux. The main control stalls the program counter while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width (≥ 8).
- `SHAMT_W`, 5, shift-amount width; must satisfy 2^SHAMT_W ≤ WIDTH.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted only when the FSM is in IDLE.
- `control` input 4: operation code, captured at accept.
- `input1` input WIDTH: operand A, captured at accept.
- `input2` input WIDTH: operand B, captured at accept.
- `shamt` input SHAMT_W: shift amount, captured at accept.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `out` output WIDTH: result, quotient, or low product.
- `out_hi` output WIDTH: high product or remainder; 0 for all other ops.
- `flags` output 3: {carry, zero, sign}.
- `div_by_zero` output 1: set with `done` for a divide with B = 0; cleared at the next accept.

## Operation
Opcodes:
- 0000 add: A+B.
- 0001 comp: ~B+1.
- 0010 and.
- 0011 xor.
- 0100 shl: logical left by `shamt`.
- 0101 shr: logical right.
- 0110 sra: arithmetic right.
- 1000 mulu: 2·WIDTH-bit product.
- 1001 divu: restoring divide.
- All other codes are illegal: `out`=0, `out_hi`=0, flags=000, 1-cycle latency.

FSM states:
- IDLE → (start) → RUN, or directly to DONE for single-cycle ops, for shifts with `shamt`=0, and for divide-by-zero.
- RUN → DONE when the iteration counter reaches 0.
- DONE → IDLE unconditionally.

Execution:
- Operands are latched at accept. Input changes while `busy` is high are ignored.
- Shifts move 1 bit per RUN cycle; the counter is loaded with `shamt`.
- mulu uses shift-add, 1 bit per cycle, WIDTH RUN cycles.
- divu uses restoring division, 1 quotient bit per cycle, WIDTH RUN cycles.
- Divide by zero: `out` = all ones, `out_hi` = A, `div_by_zero` = 1, no RUN cycles.

Flags:
- carry: carry-out of the (WIDTH+1)-bit sum for add; 0 for comp, logic ops, shifts and divu; (`out_hi`≠0) for mulu.
- zero: `out`==0, except mulu, where it is {`out_hi`,`out`}==0.
- sign: `out`[WIDTH-1]; forced to 0 for mulu and divu.

Result handling:
- `out`, `out_hi`, `flags` and `div_by_zero` are registered. They update only on entry to DONE and hold until the next op completes.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, counter=0. `busy`, `done`, `out`, `out_hi`, `flags` and `div_by_zero` all become 0 immediately.
- Reset mid-operation abandons the op. No `done` is produced for it.
- Latency is counted from the accept edge (edge k) to the edge that asserts `done`:
  - single-cycle ops, shamt=0, div-by-zero, illegal: 1 cycle (`done` high in cycle k+1).
  - shifts: `shamt`+1 cycles.
  - mulu and divu: WIDTH+1 cycles.
- `busy` rises in the cycle after accept and falls together with `done` on the return to IDLE. It is high during the DONE cycle.
- `start` during RUN or DONE is ignored and is not queued. Minimum issue interval is 2 cycles.
- `start` held high across DONE→IDLE is accepted on the first IDLE edge.
- A counter at 0 in RUN never occurs; a zero shift count bypasses RUN.

## Test plan
- add A=0xFFFFFFFF, B=0x00000001 → `done` at cycle 1, `out`=0, flags=110 (carry=1, zero=1, sign=0); `busy` high only in cycle 1.
- sra A=0x80000000, `shamt`=4 → `done` at cycle 5, `out`=0xF8000000, flags=001; then shl A=0x1, `shamt`=0 → `done` at cycle 1, `out`=0x1.
- mulu A=0x00010000, B=0x00010000 → `done` at cycle 33, `out`=0, `out_hi`=1, flags=100; mulu 0×5 → flags=010.
- divu 100/7 → `done` at cycle 33, `out`=14, `out_hi`=2. divu 100/0 → `done` at cycle 1, `out`=0xFFFFFFFF, `out_hi`=100, `div_by_zero`=1. The next add clears `div_by_zero`.
- Pulse `start` (add 3+4) at cycle 10 of a mulu, and change `input1` mid-mulu → mulu result unaffected; no second `done`; `out` after the mulu is the mulu result.
- Drive `rst`=0 at cycle 15 of a divu → `busy`, `done`, `out` and `flags` go to 0 within the same cycle. After release, a new add 2+3 completes with `out`=5 at latency 1.
